arm_multicycle_ctrl: RTL and testbench

Multicycle successor to the single-cycle ARM control decoder. A Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles. It holds the NZCV flag register internally and evaluates all 15 ARM condition codes. Sits between the instruction register and the shared-ALU/unified-memory datapath.

---
 rtl/arm_multicycle_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_arm_multicycle_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control FSM: sequences fetch/decode/execute/memory/writeback, owns NZCV, evaluates cond codes.
// Latency 2..5+MEM_WAIT cycles per instruction, no backpressure; defining BL_LINK_EN adds a LINK cycle for BL.
module arm_multicycle_ctrl #(
  parameter int unsigned MEM_WAIT   = 0,
  parameter logic [3:0]  FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  output logic       ir_write,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [3:0] flags,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_ORR   = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWRITE,
    S_MEMWB,
    S_BRANCH,
    S_LINK
  } state_t;

  state_t     state, state_next;
  logic [3:0] wait_cnt;
  logic       wait_last;
  logic [3:0] cmd;
  logic       cmd_ok, arith, is_cmp;
  logic [2:0] dp_alu;
  logic       cond_pass;
  logic       flag_we_all, flag_we_nz;

  assign cmd       = funct[4:1];
  assign is_cmp    = (cmd == CMD_CMP);
  assign wait_last = (wait_cnt == WAIT_LAST);

  // Data-processing command decode; arith selects a full NZCV update.
  always_comb begin
    cmd_ok = 1'b1;
    arith  = 1'b0;
    dp_alu = ALU_ADD;
    case (cmd)
      CMD_ADD: begin dp_alu = ALU_ADD;   arith = 1'b1; end
      CMD_SUB: begin dp_alu = ALU_SUB;   arith = 1'b1; end
      CMD_CMP: begin dp_alu = ALU_SUB;   arith = 1'b1; end
      CMD_AND: dp_alu = ALU_AND;
      CMD_ORR: dp_alu = ALU_ORR;
      CMD_MOV: dp_alu = ALU_PASSB;
      default: cmd_ok = 1'b0;
    endcase
  end

  // Condition check against the stored flags {N,Z,C,V}; 1111 never passes.
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flags[2];
      4'b0001: cond_pass = !flags[2];
      4'b0010: cond_pass = flags[1];
      4'b0011: cond_pass = !flags[1];
      4'b0100: cond_pass = flags[3];
      4'b0101: cond_pass = !flags[3];
      4'b0110: cond_pass = flags[0];
      4'b0111: cond_pass = !flags[0];
      4'b1000: cond_pass = flags[1] && !flags[2];
      4'b1001: cond_pass = !flags[1] || flags[2];
      4'b1010: cond_pass = (flags[3] == flags[0]);
      4'b1011: cond_pass = (flags[3] != flags[0]);
      4'b1100: cond_pass = !flags[2] && (flags[3] == flags[0]);
      4'b1101: cond_pass = flags[2] || (flags[3] != flags[0]);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      flags    <= FLAG_RESET;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_next;
      if (flag_we_all)
        flags <= alu_flags;
      else if (flag_we_nz)
        flags[3:2] <= alu_flags[3:2];
      if (state == S_MEMADR)
        wait_cnt <= 4'd0;
      else if ((state == S_MEMREAD || state == S_MEMWRITE) && !wait_last)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_comb begin
    state_next  = state;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = ALU_ADD;
    imm_src     = 2'b00;
    reg_src     = {(op == 2'b01) && !funct[0], (op == 2'b10)};
    instr_done  = 1'b0;
    illegal     = 1'b0;
    flag_we_all = 1'b0;
    flag_we_nz  = 1'b0;

    case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        if (!cond_pass) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else begin
          case (op)
            2'b00: begin
              if (cmd_ok) begin
                state_next = funct[5] ? S_EXECI : S_EXECR;
              end else begin
                illegal    = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
              end
            end
            2'b01: state_next = S_MEMADR;
            2'b10: begin
`ifdef BL_LINK_EN
              state_next = funct[4] ? S_LINK : S_BRANCH;
`else
              state_next = S_BRANCH;
`endif
            end
            default: begin
              illegal    = 1'b1;
              instr_done = 1'b1;
              state_next = S_FETCH;
            end
          endcase
        end
      end
      S_EXECR, S_EXECI: begin
        alu_src_b   = (state == S_EXECI) ? 2'b01 : 2'b00;
        alu_control = dp_alu;
        // CMP always sets flags even with S clear.
        if (funct[0] || is_cmp) begin
          flag_we_all = arith;
          flag_we_nz  = !arith;
        end
        if (is_cmp) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_ALUWB;
        end
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        pc_write   = (rd == 4'd15);
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMADR: begin
        alu_src_b  = 2'b01;
        imm_src    = 2'b01;
        state_next = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (wait_last)
          state_next = S_MEMWB;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        if (wait_last) begin
          mem_write  = 1'b1;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        pc_write   = (rd == 4'd15);
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        imm_src    = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_LINK: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_PASSB;
        reg_write   = 1'b1;
        reg_src     = 2'b10;
        state_next  = S_BRANCH;
      end
      default: state_next = S_FETCH;
    endcase

    // Synchronous reset aborts the current instruction without any write.
    if (reset) begin
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      instr_done  = 1'b0;
      illegal     = 1'b0;
      flag_we_all = 1'b0;
      flag_we_nz  = 1'b0;
      state_next  = S_FETCH;
    end
  end

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Bench for arm_multicycle_ctrl: per-cycle expected control vectors queued at issue, compared against sampled outputs.
module tb_arm_multicycle_ctrl;

  localparam int MEM_WAIT = 3;
  localparam logic [2:0] A_ADD = 3'b000, A_SUB = 3'b001, A_AND = 3'b010, A_ORR = 3'b011, A_PASSB = 3'b100;

  logic       clk, reset;
  logic [3:0] cond, rd, alu_flags, flags;
  logic [1:0] op;
  logic [5:0] funct;
  logic       ir_write, pc_write, adr_src, mem_write, reg_write, instr_done, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, reg_src;
  logic [2:0] alu_control;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  arm_multicycle_ctrl #(.MEM_WAIT(MEM_WAIT), .FLAG_RESET(4'b0000)) dut (
    .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .rd(rd), .alu_flags(alu_flags),
    .ir_write(ir_write), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_control(alu_control), .imm_src(imm_src), .reg_src(reg_src), .flags(flags),
    .instr_done(instr_done), .illegal(illegal)
  );

  // stb = {ir_write, pc_write, mem_write, reg_write, instr_done, illegal}
  // ctl = {adr_src, alu_src_a, alu_src_b, alu_control, result_src, imm_src, reg_src}
  typedef struct packed { logic [5:0] stb; logic [3:0] flg; logic [13:0] ctl; logic [13:0] msk; } exp_t;
  typedef struct packed { logic [5:0] stb; logic [3:0] flg; logic [13:0] ctl; } obs_t;

  exp_t       exp_q[$];
  obs_t       obs_q[$];
  int         n_cmp = 0, n_bad = 0;
  logic [3:0] mflags;

  function automatic exp_t ex(input logic [5:0] stb, input logic [13:0] ctl, input logic [13:0] msk);
    exp_t e;
    e.stb = stb; e.flg = mflags; e.ctl = ctl; e.msk = msk;
    return e;
  endfunction

  function automatic exp_t e_fetch();
    return ex(6'b110000, {1'b0, 2'b01, 2'b10, A_ADD, 2'b10, 2'b00, 2'b00},
                         {1'b1, 2'b11, 2'b11, 3'b111, 2'b11, 2'b00, 2'b00});
  endfunction
  function automatic exp_t e_decode(input logic done, input logic ill, input logic [1:0] rs, input logic rs_chk);
    return ex({4'b0000, done, ill}, {1'b0, 2'b01, 2'b10, A_ADD, 2'b00, 2'b00, rs},
                                    {1'b0, 2'b11, 2'b11, 3'b111, 2'b00, 2'b00, {2{rs_chk}}});
  endfunction
  function automatic exp_t e_exec(input logic imm, input logic [2:0] aluc, input logic done);
    return ex({4'b0000, done, 1'b0}, {1'b0, 2'b00, {1'b0, imm}, aluc, 2'b00, 2'b00, 2'b00},
                                     {1'b0, 2'b11, 2'b11, 3'b111, 2'b00, 2'b11, 2'b00});
  endfunction
  function automatic exp_t e_wb(input logic pcw, input logic [1:0] rs);
    return ex({1'b0, pcw, 1'b0, 1'b1, 1'b1, 1'b0}, {1'b0, 2'b00, 2'b00, 3'b000, rs, 2'b00, 2'b00},
                                                   {1'b0, 2'b00, 2'b00, 3'b000, 2'b11, 2'b00, 2'b00});
  endfunction
  function automatic exp_t e_madr();
    return ex(6'b000000, {1'b0, 2'b00, 2'b01, A_ADD, 2'b00, 2'b01, 2'b00},
                         {1'b0, 2'b11, 2'b11, 3'b111, 2'b00, 2'b11, 2'b00});
  endfunction
  function automatic exp_t e_mem(input logic wl);
    return ex({2'b00, wl, 1'b0, wl, 1'b0}, {1'b1, 13'd0}, {1'b1, 13'd0});
  endfunction
  function automatic exp_t e_br();
    return ex(6'b010010, {1'b0, 2'b10, 2'b01, A_ADD, 2'b10, 2'b10, 2'b00},
                         {1'b0, 2'b11, 2'b11, 3'b111, 2'b11, 2'b11, 2'b00});
  endfunction
  function automatic exp_t e_rst();
    return ex(6'b000000, 14'd0, 14'd0);
  endfunction

  // Reference ARM condition table on {N,Z,C,V}.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic [3:0] af);
    cond = c; op = o; funct = f; rd = r; alu_flags = af;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_q.push_back(obs_t'({ {ir_write, pc_write, mem_write, reg_write, instr_done, illegal}, flags,
                               {adr_src, alu_src_a, alu_src_b, alu_control, result_src, imm_src, reg_src} }));
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    exp_t e; obs_t o; int k = 0;
    reset = 1'b1;
    issue(4'hE, 2'b00, 6'b001000, 4'd2, 4'b1111);
    repeat (2) @(posedge clk);
    #1;
    repeat (3) exp_q.push_back(e_rst());
    cycles(3);
    reset = 1'b0;
    // ADDEQ with Z=0 right after reset: fetch then cond-fail done in decode.
    issue(4'h0, 2'b00, 6'b001000, 4'd2, 4'b0000);
    exp_q.push_back(e_fetch());
    exp_q.push_back(e_decode(1'b1, 1'b0, 2'b00, 1'b1));
    cycles(2);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL reset cycle %0d: not sampled", k); end
      else begin
        o = obs_q.pop_front();
        if (o.stb !== e.stb || o.flg !== e.flg || (o.ctl & e.msk) !== (e.ctl & e.msk)) begin
          n_bad++;
          $display("FAIL reset cycle %0d: got stb=%b flags=%b ctl=%b, want stb=%b flags=%b ctl=%b", k, o.stb, o.flg, o.ctl & e.msk, e.stb, e.flg, e.ctl & e.msk);
        end
      end
      k++;
    end
  endtask

  typedef struct { logic [3:0] c; logic [5:0] f; logic [3:0] r; logic [3:0] af; logic [2:0] aluc; } dp_t;

  task automatic test_dp();
    exp_t e; obs_t o; int k = 0;
    logic ok, cmp;
    dp_t tbl[9] = '{
      '{4'hE, 6'b000101, 4'd1,  4'b0110, A_SUB},    // SUBS r1,r1,r1
      '{4'h0, 6'b001000, 4'd2,  4'b1111, A_ADD},    // ADDEQ with Z=1
      '{4'hE, 6'b100001, 4'd3,  4'b1001, A_AND},    // ANDS imm
      '{4'hE, 6'b011000, 4'd15, 4'b0000, A_ORR},    // ORR to pc
      '{4'hE, 6'b111011, 4'd4,  4'b0101, A_PASSB},  // MOVS imm
      '{4'hE, 6'b001001, 4'd5,  4'b1011, A_ADD},    // ADDS
      '{4'hE, 6'b010100, 4'd0,  4'b0100, A_SUB},    // CMP
      '{4'h1, 6'b001000, 4'd6,  4'b0000, A_ADD},    // ADDNE with Z=1
      '{4'hE, 6'b011001, 4'd6,  4'b1000, A_ORR}     // ORRS
    };
    foreach (tbl[i]) begin
      ok  = cond_ok(tbl[i].c, mflags);
      cmp = (tbl[i].f[4:1] == 4'b1010);
      issue(tbl[i].c, 2'b00, tbl[i].f, tbl[i].r, tbl[i].af);
      exp_q.push_back(e_fetch());
      exp_q.push_back(e_decode(!ok, 1'b0, 2'b00, 1'b1));
      if (ok) begin
        exp_q.push_back(e_exec(tbl[i].f[5], tbl[i].aluc, cmp));
        if (tbl[i].f[0] || cmp) begin
          if (tbl[i].f[4:1] inside {4'b0100, 4'b0010, 4'b1010}) mflags = tbl[i].af;
          else mflags[3:2] = tbl[i].af[3:2];
        end
        if (!cmp) exp_q.push_back(e_wb(tbl[i].r == 4'd15, 2'b00));
      end
      cycles(!ok ? 2 : (cmp ? 3 : 4));
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL dp cycle %0d: not sampled", k); end
      else begin
        o = obs_q.pop_front();
        if (o.stb !== e.stb || o.flg !== e.flg || (o.ctl & e.msk) !== (e.ctl & e.msk)) begin
          n_bad++;
          $display("FAIL dp cycle %0d: got stb=%b flags=%b ctl=%b, want stb=%b flags=%b ctl=%b", k, o.stb, o.flg, o.ctl & e.msk, e.stb, e.flg, e.ctl & e.msk);
        end
      end
      k++;
    end
  endtask

  task automatic test_mem();
    exp_t e; obs_t o; int k = 0;
    // STR r3
    issue(4'hE, 2'b01, 6'b011000, 4'd3, 4'b0000);
    exp_q.push_back(e_fetch());
    exp_q.push_back(e_decode(1'b0, 1'b0, 2'b10, 1'b1));
    exp_q.push_back(e_madr());
    repeat (MEM_WAIT) exp_q.push_back(e_mem(1'b0));
    exp_q.push_back(e_mem(1'b1));
    cycles(4 + MEM_WAIT);
    // LDR pc, then LDR r7
    for (int j = 0; j < 2; j++) begin
      issue(4'hE, 2'b01, 6'b011001, (j == 0) ? 4'd15 : 4'd7, 4'b1111);
      exp_q.push_back(e_fetch());
      exp_q.push_back(e_decode(1'b0, 1'b0, 2'b00, 1'b1));
      exp_q.push_back(e_madr());
      repeat (MEM_WAIT + 1) exp_q.push_back(e_mem(1'b0));
      exp_q.push_back(e_wb(j == 0, 2'b01));
      cycles(5 + MEM_WAIT);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL mem cycle %0d: not sampled", k); end
      else begin
        o = obs_q.pop_front();
        if (o.stb !== e.stb || o.flg !== e.flg || (o.ctl & e.msk) !== (e.ctl & e.msk)) begin
          n_bad++;
          $display("FAIL mem cycle %0d: got stb=%b flags=%b ctl=%b, want stb=%b flags=%b ctl=%b", k, o.stb, o.flg, o.ctl & e.msk, e.stb, e.flg, e.ctl & e.msk);
        end
      end
      k++;
    end
  endtask

  task automatic test_illegal();
    exp_t e; obs_t o; int k = 0;
    issue(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000);
    exp_q.push_back(e_fetch());
    exp_q.push_back(e_decode(1'b1, 1'b1, 2'b00, 1'b0));
    cycles(2);
    // EORS is unsupported: no flag change despite S=1
    issue(4'hE, 2'b00, 6'b000011, 4'd1, 4'b1111);
    exp_q.push_back(e_fetch());
    exp_q.push_back(e_decode(1'b1, 1'b1, 2'b00, 1'b1));
    cycles(2);
    issue(4'hE, 2'b10, 6'b000000, 4'd0, 4'b1111);
    exp_q.push_back(e_fetch());
    exp_q.push_back(e_decode(1'b0, 1'b0, 2'b01, 1'b1));
    exp_q.push_back(e_br());
    cycles(3);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL illegal cycle %0d: not sampled", k); end
      else begin
        o = obs_q.pop_front();
        if (o.stb !== e.stb || o.flg !== e.flg || (o.ctl & e.msk) !== (e.ctl & e.msk)) begin
          n_bad++;
          $display("FAIL illegal cycle %0d: got stb=%b flags=%b ctl=%b, want stb=%b flags=%b ctl=%b", k, o.stb, o.flg, o.ctl & e.msk, e.stb, e.flg, e.ctl & e.msk);
        end
      end
      k++;
    end
  endtask

  task automatic test_cond();
    exp_t e; obs_t o; int k = 0;
    logic ok;
    logic [3:0] fv[8] = '{4'b0000, 4'b0100, 4'b1000, 4'b0010, 4'b0001, 4'b1001, 4'b0110, 4'b1111};
    foreach (fv[i]) begin
      issue(4'hE, 2'b00, 6'b010100, 4'd0, fv[i]);
      exp_q.push_back(e_fetch());
      exp_q.push_back(e_decode(1'b0, 1'b0, 2'b00, 1'b1));
      exp_q.push_back(e_exec(1'b0, A_SUB, 1'b1));
      cycles(3);
      mflags = fv[i];
      for (int c = 0; c < 16; c++) begin
        ok = cond_ok(4'(c), mflags);
        issue(4'(c), 2'b10, 6'b000000, 4'd0, ~fv[i]);
        exp_q.push_back(e_fetch());
        exp_q.push_back(e_decode(!ok, 1'b0, 2'b01, 1'b1));
        if (ok) exp_q.push_back(e_br());
        cycles(ok ? 3 : 2);
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL cond cycle %0d: not sampled", k); end
      else begin
        o = obs_q.pop_front();
        if (o.stb !== e.stb || o.flg !== e.flg || (o.ctl & e.msk) !== (e.ctl & e.msk)) begin
          n_bad++;
          $display("FAIL cond cycle %0d: got stb=%b flags=%b ctl=%b, want stb=%b flags=%b ctl=%b", k, o.stb, o.flg, o.ctl & e.msk, e.stb, e.flg, e.ctl & e.msk);
        end
      end
      k++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; obs_t o; int k = 0;
    issue(4'hE, 2'b01, 6'b011001, 4'd9, 4'b0000);
    exp_q.push_back(e_fetch());
    exp_q.push_back(e_decode(1'b0, 1'b0, 2'b00, 1'b1));
    exp_q.push_back(e_madr());
    repeat (MEM_WAIT) exp_q.push_back(e_mem(1'b0));
    cycles(3 + MEM_WAIT);
    // Reset lands on the last MEMREAD cycle: no MEMWB may follow.
    reset = 1'b1;
    exp_q.push_back(e_rst());
    cycles(1);
    reset = 1'b0;
    mflags = 4'b0000;
    issue(4'h0, 2'b00, 6'b001000, 4'd2, 4'b0000);
    exp_q.push_back(e_fetch());
    exp_q.push_back(e_decode(1'b1, 1'b0, 2'b00, 1'b1));
    cycles(2);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL reset_mid cycle %0d: not sampled", k); end
      else begin
        o = obs_q.pop_front();
        if (o.stb !== e.stb || o.flg !== e.flg || (o.ctl & e.msk) !== (e.ctl & e.msk)) begin
          n_bad++;
          $display("FAIL reset_mid cycle %0d: got stb=%b flags=%b ctl=%b, want stb=%b flags=%b ctl=%b", k, o.stb, o.flg, o.ctl & e.msk, e.stb, e.flg, e.ctl & e.msk);
        end
      end
      k++;
    end
  endtask

  initial begin
    reset  = 1'b1;
    mflags = 4'b0000;
    issue(4'hE, 2'b00, 6'b001000, 4'd2, 4'b0000);
    test_reset();
    test_dp();
    test_mem();
    test_illegal();
    test_cond();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
